data_mem_resp: RTL and testbench

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp_pkg.sv | 16 +
 rtl/data_mem_resp_if.sv | 26 ++
 rtl/data_mem_resp_lane_align.sv | 50 +++++
 rtl/data_mem_resp.sv | 136 +++++++++++++
 tb/tb_data_mem_resp.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the data memory responder: access sizes, FSM states,
// and the legal latency range.
package data_mem_resp_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } st_t;
endpackage

// File: rtl/data_mem_resp_if.sv
// Processor-side data memory port between the pipeline (master) and the memory (slave).
// The master raises req and holds every request field stable while stall=1.
// The access completes in the single cycle where done=1; rdata and err are valid only then.
// stall is req & ~done.
interface data_mem_resp_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        stall;

  modport master (
    output req, wr, addr, wdata, size, sign_ext,
    input  rdata, done, err, stall
  );

  modport slave (
    input  req, wr, addr, wdata, size, sign_ext,
    output rdata, done, err, stall
  );
endinterface

// File: rtl/data_mem_resp_lane_align.sv
// Byte-lane steering: store byte-enables and replicated write data, load lane
// extraction with sign/zero extension, and the misaligned/illegal flag.
module dmem_lane_align
  import data_mem_resp_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wshift,
  output logic [31:0] load_data,
  output logic        bad
);
  logic [31:0] shifted;

  always_comb begin
    be        = 4'b0000;
    wshift    = 32'h0;
    load_data = 32'h0;
    bad       = 1'b0;
    shifted   = rword >> {addr_lo, 3'b000};
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wshift    = {4{wdata[7:0]}};
        load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        bad       = addr_lo[0];
        be        = 4'b0011 << addr_lo;
        wshift    = {2{wdata[15:0]}};
        load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        bad       = (addr_lo != 2'b00);
        be        = 4'b1111;
        wshift    = wdata;
        load_data = rword;
      end
      default: bad = 1'b1;
    endcase
    // A rejected access must neither touch the array nor return data.
    if (bad) begin
      be        = 4'b0000;
      load_data = 32'h0;
    end
  end
endmodule

// File: rtl/data_mem_resp.sv
// Fixed-latency data memory for the processor load/store port: IDLE/WAIT/RESP FSM,
// a byte-enabled word array, and a one-cycle done/err response.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  data_mem_resp_if.slave   bus,
  output st_t              dbg_state
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit ONE_CYCLE = (LATENCY == 1);

  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_lat_check
    $error("data_mem_resp: LATENCY outside legal range");
  end

  st_t            state;
  logic [3:0]     cnt;
  logic           cap_wr;
  logic [AW+1:0]  cap_addr;
  logic [31:0]    cap_wdata;
  logic [1:0]     cap_size;
  logic           cap_sx;
  logic           done_r;
  logic           err_r;
  logic [31:0]    rdata_r;

  logic [31:0]    mem [DEPTH_WORDS];

  logic           f_wr;
  logic [AW+1:0]  f_addr;
  logic [31:0]    f_wdata;
  logic [1:0]     f_size;
  logic           f_sx;
  logic [AW-1:0]  f_idx;
  logic [3:0]     be;
  logic [31:0]    wshift;
  logic [31:0]    load_data;
  logic           bad;
  logic           finish;

  // In IDLE the live request drives the lane logic so a one-cycle latency can
  // respond on the acceptance edge; otherwise the captured request does.
  always_comb begin
    f_wr    = cap_wr;
    f_addr  = cap_addr;
    f_wdata = cap_wdata;
    f_size  = cap_size;
    f_sx    = cap_sx;
    if (state == ST_IDLE) begin
      f_wr    = bus.wr;
      f_addr  = bus.addr[AW+1:0];
      f_wdata = bus.wdata;
      f_size  = bus.size;
      f_sx    = bus.sign_ext;
    end
  end

  assign f_idx = f_addr[AW+1:2];

  dmem_lane_align u_align (
    .addr_lo   (f_addr[1:0]),
    .size      (f_size),
    .sign_ext  (f_sx),
    .wdata     (f_wdata),
    .rword     (mem[f_idx]),
    .be        (be),
    .wshift    (wshift),
    .load_data (load_data),
    .bad       (bad)
  );

  assign finish = (state == ST_IDLE && bus.req && ONE_CYCLE) ||
                  (state == ST_WAIT && cnt == 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      cap_wr    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= 32'h0;
      cap_size  <= 2'b00;
      cap_sx    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      rdata_r   <= 32'h0;
    end else begin
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0;
      case (state)
        ST_IDLE: if (bus.req) begin
          cap_wr    <= bus.wr;
          cap_addr  <= bus.addr[AW+1:0];
          cap_wdata <= bus.wdata;
          cap_size  <= bus.size;
          cap_sx    <= bus.sign_ext;
          cnt       <= 4'(LATENCY - 1);
          state     <= ONE_CYCLE ? ST_RESP : ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (finish) begin
        done_r  <= 1'b1;
        err_r   <= bad;
        rdata_r <= (bad || f_wr) ? 32'h0 : load_data;
      end
    end
  end

  // Stores land on the edge that leaves RESP; reset holds the FSM in IDLE, so
  // an aborted store never reaches this point.
  always_ff @(posedge clk) begin
    if (state == ST_RESP && cap_wr && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[f_idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  assign bus.done  = done_r;
  assign bus.err   = err_r;
  assign bus.rdata = rdata_r;
  assign bus.stall = bus.req & ~done_r;
  assign dbg_state = state;
endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: three instances (LATENCY 2, 4, 1) share one stimulus
// bus; sel picks which one sees req and whose outputs are observed.
module tb_data_mem_resp;
  import data_mem_resp_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rst_n;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_s, wr_s, sx_s;
  logic [31:0] addr_s, wdata_s;
  logic [1:0]  size_s;
  int          sel;

  data_mem_resp_if bus2 ();
  data_mem_resp_if bus4 ();
  data_mem_resp_if bus1 ();

  assign bus2.req = req_s && (sel == 0);
  assign bus4.req = req_s && (sel == 1);
  assign bus1.req = req_s && (sel == 2);
  assign bus2.wr = wr_s;       assign bus4.wr = wr_s;       assign bus1.wr = wr_s;
  assign bus2.addr = addr_s;   assign bus4.addr = addr_s;   assign bus1.addr = addr_s;
  assign bus2.wdata = wdata_s; assign bus4.wdata = wdata_s; assign bus1.wdata = wdata_s;
  assign bus2.size = size_s;   assign bus4.size = size_s;   assign bus1.size = size_s;
  assign bus2.sign_ext = sx_s; assign bus4.sign_ext = sx_s; assign bus1.sign_ext = sx_s;

  st_t st2, st4, st1;

  data_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst_n[0]), .bus(bus2), .dbg_state(st2));
  data_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst_n[1]), .bus(bus4), .dbg_state(st4));
  data_mem_resp #(.DEPTH_WORDS(1024), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst_n[2]), .bus(bus1), .dbg_state(st1));

  logic        done_m, err_m, stall_m;
  logic [31:0] rdata_m;
  st_t         st_m;

  always_comb begin
    done_m = bus2.done; err_m = bus2.err; stall_m = bus2.stall; rdata_m = bus2.rdata; st_m = st2;
    case (sel)
      1: begin done_m = bus4.done; err_m = bus4.err; stall_m = bus4.stall; rdata_m = bus4.rdata; st_m = st4; end
      2: begin done_m = bus1.done; err_m = bus1.err; stall_m = bus1.stall; rdata_m = bus1.rdata; st_m = st1; end
      default: ;
    endcase
  end

  // scoreboard: {err, rdata}
  logic [32:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int last_done_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic pop_and_check(input string tag);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rdata_m, e[31:0]);
      check({tag, "_err"}, 32'(err_m), 32'(e[32]));
    end
  endtask

  // Drives one access (req stays high afterwards) and waits for its done.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic sx,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int lat, stalls;
    bit got;
    @(negedge clk);
    req_s = 1'b1; wr_s = w; addr_s = a; wdata_s = d; size_s = sz; sx_s = sx;
    exp_q.push_back({exp_err, exp_rd});
    lat = 0; stalls = 0; got = 1'b0;
    #1;
    while (!got && lat < 40) begin
      if (done_m) got = 1'b1;
      else begin
        stalls += int'(stall_m);
        @(negedge clk); #1;
        lat++;
      end
    end
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_stall"}, stalls, exp_lat);
    last_done_cyc = cyc;
    pop_and_check(tag);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    req_s = 1'b0; wr_s = 1'b0;
    #1;
    check({tag, "_rdata_idle"}, rdata_m, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int c1, c2, c3, pulses, lat;
    bit got;
    logic [31:0] a, d, sh, ex;
    logic [7:0] bv;
    int k;
    logic sx;

    rst_n = 3'b000; sel = 0;
    req_s = 1'b0; wr_s = 1'b0; sx_s = 1'b0; addr_s = 32'h0; wdata_s = 32'h0; size_s = SZ_W;
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      check("rst_done", 32'(done_m), 32'd0);
      check("rst_err", 32'(err_m), 32'd0);
      check("rst_rdata", rdata_m, 32'h0);
      check("rst_stall", 32'(stall_m), 32'd0);
      check("rst_state", 32'(st_m), 32'(ST_IDLE));
    end
    sel = 0;
    @(posedge clk); #2 rst_n = 3'b111;

    // LATENCY=2: basic word, byte lanes, misalignment, wrap
    access("st_w100", 1, 32'h100, 32'hDEADBEEF, SZ_W, 0, 32'h0, 0, 2);
    access("ld_w100", 0, 32'h100, 32'h0, SZ_W, 0, 32'hDEADBEEF, 0, 2);
    idle_check("after_ld_w100");
    access("st_b103", 1, 32'h103, 32'h00000080, SZ_B, 0, 32'h0, 0, 2);
    access("ld_b103_sx", 0, 32'h103, 32'h0, SZ_B, 1, 32'hFFFFFF80, 0, 2);
    access("ld_b103_zx", 0, 32'h103, 32'h0, SZ_B, 0, 32'h00000080, 0, 2);
    access("ld_w100_b", 0, 32'h100, 32'h0, SZ_W, 1, 32'h80ADBEEF, 0, 2);
    access("ld_h101_mis", 0, 32'h101, 32'h0, SZ_H, 1, 32'h0, 1, 2);
    access("ld_w100_c", 0, 32'h100, 32'h0, SZ_W, 0, 32'h80ADBEEF, 0, 2);
    access("st_w102_mis", 1, 32'h102, 32'h11111111, SZ_W, 0, 32'h0, 1, 2);
    access("ld_w100_d", 0, 32'h100, 32'h0, SZ_W, 0, 32'h80ADBEEF, 0, 2);
    access("ld_h102_sx", 0, 32'h102, 32'h0, SZ_H, 1, 32'hFFFF80AD, 0, 2);
    access("ld_h102_zx", 0, 32'h102, 32'h0, SZ_H, 0, 32'h000080AD, 0, 2);
    access("ld_sz11", 0, 32'h100, 32'h0, 2'b11, 0, 32'h0, 1, 2);
    access("st_w1004", 1, 32'h1004, 32'h12345678, SZ_W, 0, 32'h0, 0, 2);
    access("ld_w0004", 0, 32'h0004, 32'h0, SZ_W, 0, 32'h12345678, 0, 2);
    access("st_w300", 1, 32'h300, 32'h0, SZ_W, 0, 32'h0, 0, 2);
    access("st_h302", 1, 32'h302, 32'hFFFF8001, SZ_H, 0, 32'h0, 0, 2);
    access("ld_w300", 0, 32'h300, 32'h0, SZ_W, 0, 32'h80010000, 0, 2);
    idle_check("after_ld_w300");

    for (int i = 0; i < 4; i++) begin
      a  = 32'($urandom_range(32'h100, 32'h1FF)) << 2;
      d  = $urandom;
      k  = $urandom_range(0, 3);
      sx = 1'($urandom_range(0, 1));
      sh = d >> (8 * k);
      bv = sh[7:0];
      ex = sx ? {{24{bv[7]}}, bv} : {24'h0, bv};
      access("rnd_st", 1, a, d, SZ_W, 0, 32'h0, 0, 2);
      access("rnd_ld", 0, a, 32'h0, SZ_W, 0, d, 0, 2);
      access("rnd_ldb", 0, a + 32'(k), 32'h0, SZ_B, sx, ex, 0, 2);
    end
    idle_check("after_rnd");

    // LATENCY=4: reset mid-store discards it, array contents survive
    sel = 1;
    access("l4_st_w200", 1, 32'h200, 32'h55555555, SZ_W, 0, 32'h0, 0, 4);
    access("l4_ld_w200", 0, 32'h200, 32'h0, SZ_W, 0, 32'h55555555, 0, 4);
    @(negedge clk);
    req_s = 1'b1; wr_s = 1'b1; addr_s = 32'h200; wdata_s = 32'hAAAAAAAA; size_s = SZ_W;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n[1] = 1'b0;
    #1;
    check("l4_rst_done", 32'(done_m), 32'd0);
    check("l4_rst_rdata", rdata_m, 32'h0);
    check("l4_rst_state", 32'(st_m), 32'(ST_IDLE));
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) req_s = 1'b0;
      #1;
      if (done_m) pulses++;
    end
    @(posedge clk); #2 rst_n[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (done_m) pulses++;
    end
    check("l4_abort_pulses", pulses, 0);
    @(posedge clk); #2;
    access("l4_ld_after_rst", 0, 32'h200, 32'h0, SZ_W, 0, 32'h55555555, 0, 4);

    // LATENCY=4: req dropped during WAIT still completes
    idle_check("l4_idle");
    @(negedge clk);
    req_s = 1'b1; wr_s = 1'b0; addr_s = 32'h200; size_s = SZ_W; sx_s = 1'b0;
    exp_q.push_back({1'b0, 32'h55555555});
    @(negedge clk);
    req_s = 1'b0;
    #1;
    lat = 1; got = 1'b0;
    while (!got && lat < 40) begin
      if (done_m) got = 1'b1;
      else begin @(negedge clk); #1; lat++; end
    end
    check("l4_drop_done", 32'(got), 32'd1);
    check("l4_drop_lat", lat, 4);
    pop_and_check("l4_drop");

    // LATENCY=1: back-to-back loads with req held high
    sel = 2;
    access("l1_st0", 1, 32'h10, 32'h01010101, SZ_W, 0, 32'h0, 0, 1);
    access("l1_st1", 1, 32'h14, 32'h02020202, SZ_W, 0, 32'h0, 0, 1);
    access("l1_st2", 1, 32'h18, 32'h03030303, SZ_W, 0, 32'h0, 0, 1);
    access("l1_ld0", 0, 32'h10, 32'h0, SZ_W, 0, 32'h01010101, 0, 1);
    c1 = last_done_cyc;
    access("l1_ld1", 0, 32'h14, 32'h0, SZ_W, 0, 32'h02020202, 0, 1);
    c2 = last_done_cyc;
    access("l1_ld2", 0, 32'h18, 32'h0, SZ_W, 0, 32'h03030303, 0, 1);
    c3 = last_done_cyc;
    check("l1_gap01", c2 - c1, 2);
    check("l1_gap12", c3 - c2, 2);
    idle_check("l1_idle");

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
